dma_read_responder: RTL and testbench

Synthesizable responder for the DMA read-command/read-data stream pair issued by the MPI and collective control blocks. Accepts read commands (address, byte length), queues them, and returns a 512-bit AXI-Stream burst per command with a deterministic address-derived payload, then a per-command status word. Used as a host-DMA stand-in for on-chip loopback and self-test builds, and as the read-side bus-functional model in block benches.

---
 rtl/dma_read_responder.sv | 179 +++++++++++++++++
 tb/tb_dma_read_responder.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_read_responder.sv
// dma_read_responder: host-DMA stand-in for the read command / read data
// stream pair. Queues read commands and answers each one with a burst of
// address-derived 512-bit beats followed by a one-byte status word.
//
// Handshakes: every stream transfers on the rising edge where valid && ready
// are both high. A producer holds valid and its payload unchanged until that
// transfer, and ready never depends on the opposing valid within a cycle.
module dma_read_responder #(
  parameter int DATA_WIDTH = 512,
  parameter int CMD_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s_axis_read_cmd_valid,
  output logic                    s_axis_read_cmd_ready,
  input  logic [63:0]             s_axis_read_cmd_address,
  input  logic [31:0]             s_axis_read_cmd_length,
  output logic                    m_axis_read_data_valid,
  input  logic                    m_axis_read_data_ready,
  output logic [DATA_WIDTH-1:0]   m_axis_read_data_data,
  output logic [DATA_WIDTH/8-1:0] m_axis_read_data_keep,
  output logic                    m_axis_read_data_last,
  output logic                    m_axis_read_sts_valid,
  input  logic                    m_axis_read_sts_ready,
  output logic [7:0]              m_axis_read_sts_data,
  output logic [1:0]              dbg_state
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int LANES  = DATA_WIDTH / 64;
  localparam int AW     = $clog2(CMD_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STS  = 2'd2
  } state_t;

  state_t              state;
  logic [63:0]         fifo_addr [CMD_DEPTH];
  logic [31:0]         fifo_len  [CMD_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  logic [63:0]         head_addr;
  logic [31:0]         head_len;
  logic [32:0]         head_beats;

  logic [63:0]         cur_addr;
  logic [32:0]         beats_left;   // beats still to present after the one on the bus
  logic [5:0]          rem;
  logic [6:0]          seq;

  // Every 64-bit lane of a beat carries the beat's byte address.
  function automatic logic [DATA_WIDTH-1:0] lanes_of(input logic [63:0] a);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*64 +: 64] = a;
    return r;
  endfunction

  // Byte enables for the final beat; a zero remainder means a full beat.
  function automatic logic [KEEP_W-1:0] last_keep(input logic [5:0] r);
    logic [KEEP_W-1:0] ones;
    ones = '1;
    if (r == 6'd0) return ones;
    return ~(ones << r);
  endfunction

  assign fifo_full             = (count == (AW+1)'(CMD_DEPTH));
  assign fifo_empty            = (count == '0);
  assign s_axis_read_cmd_ready = ~fifo_full;
  assign push                  = s_axis_read_cmd_valid && !fifo_full;
  assign pop                   = (state == S_IDLE) && !fifo_empty;

  assign head_addr  = fifo_addr[rd_ptr];
  assign head_len   = fifo_len[rd_ptr];
  // 33-bit sum so a length of 0xFFFFFFFF rounds up without wrapping to zero.
  assign head_beats = ({1'b0, head_len} + 33'd63) >> 6;

  assign dbg_state  = state;

  // Command storage; stale entries are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= s_axis_read_cmd_address;
      fifo_len[wr_ptr]  <= s_axis_read_cmd_length;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Engine FSM: pop a command, stream its beats, then hand back status.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                  <= S_IDLE;
      m_axis_read_data_valid <= 1'b0;
      m_axis_read_data_data  <= '0;
      m_axis_read_data_keep  <= '0;
      m_axis_read_data_last  <= 1'b0;
      m_axis_read_sts_valid  <= 1'b0;
      m_axis_read_sts_data   <= '0;
      cur_addr               <= '0;
      beats_left             <= '0;
      rem                    <= '0;
      seq                    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            rem <= head_len[5:0];
            if (head_beats != 33'd0) begin
              m_axis_read_data_valid <= 1'b1;
              m_axis_read_data_data  <= lanes_of(head_addr);
              m_axis_read_data_last  <= (head_beats == 33'd1);
              m_axis_read_data_keep  <= (head_beats == 33'd1) ? last_keep(head_len[5:0]) : '1;
              cur_addr               <= head_addr + 64'd64;
              beats_left             <= head_beats - 33'd1;
              state                  <= S_DATA;
            end else begin
              // Zero-length command: no beats, error status straight away.
              m_axis_read_sts_valid <= 1'b1;
              m_axis_read_sts_data  <= {1'b1, seq};
              state                 <= S_STS;
            end
          end
        end
        S_DATA: begin
          if (m_axis_read_data_ready) begin
            if (m_axis_read_data_last) begin
              m_axis_read_data_valid <= 1'b0;
              m_axis_read_data_last  <= 1'b0;
              m_axis_read_data_keep  <= '0;
              m_axis_read_data_data  <= '0;
              m_axis_read_sts_valid  <= 1'b1;
              m_axis_read_sts_data   <= {1'b0, seq};
              state                  <= S_STS;
            end else begin
              m_axis_read_data_data <= lanes_of(cur_addr);
              m_axis_read_data_last <= (beats_left == 33'd1);
              m_axis_read_data_keep <= (beats_left == 33'd1) ? last_keep(rem) : '1;
              cur_addr              <= cur_addr + 64'd64;
              beats_left            <= beats_left - 33'd1;
            end
          end
        end
        S_STS: begin
          if (m_axis_read_sts_ready) begin
            m_axis_read_sts_valid <= 1'b0;
            seq                   <= seq + 7'd1;
            state                 <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_read_responder.sv
// Directed bench for dma_read_responder: long bursts, partial last beat,
// zero length, command FIFO backpressure, random stalls, maximum length
// with address wrap, and reset in the middle of a burst.
module tb_dma_read_responder;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [63:0]  cmd_addr = '0;
  logic [31:0]  cmd_len = '0;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic [511:0] data_data;
  logic [63:0]  data_keep;
  logic         data_last;
  logic         sts_valid;
  logic         sts_ready = 1'b0;
  logic [7:0]   sts_data;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_bad = 0;

  logic [511:0] got_data[$];
  logic [63:0]  got_keep[$];
  logic         got_last[$];
  int           got_cyc[$];
  logic [7:0]   got_sts;
  int           sts_cyc;
  logic [7:0]   exp_q[$];

  localparam logic [63:0] ALL_KEEP = 64'hFFFF_FFFF_FFFF_FFFF;

  dma_read_responder #(.DATA_WIDTH(512), .CMD_DEPTH(4)) dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .s_axis_read_cmd_valid   (cmd_valid),
    .s_axis_read_cmd_ready   (cmd_ready),
    .s_axis_read_cmd_address (cmd_addr),
    .s_axis_read_cmd_length  (cmd_len),
    .m_axis_read_data_valid  (data_valid),
    .m_axis_read_data_ready  (data_ready),
    .m_axis_read_data_data   (data_data),
    .m_axis_read_data_keep   (data_keep),
    .m_axis_read_data_last   (data_last),
    .m_axis_read_sts_valid   (sts_valid),
    .m_axis_read_sts_ready   (sts_ready),
    .m_axis_read_sts_data    (sts_data),
    .dbg_state               (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] lanes(input logic [63:0] a);
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = a;
    return r;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    cmd_valid = 1'b0;
    data_ready = 1'b0;
    sts_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the command handshake.
  task automatic send_cmd(input logic [63:0] a, input logic [31:0] l, output int hs_cyc);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = l;
    hs_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        hs_cyc = cyc;
        @(posedge clk); @(negedge clk);
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (hs_cyc < 0) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout got no handshake required handshake within 200 cycles");
    end
  endtask

  // Consumes one burst and its status, recording every beat.
  task automatic drain(input bit rnd, output bit ok);
    logic [511:0] hold_d;
    logic [63:0]  hold_k;
    logic         hold_l;
    logic [7:0]   hold_s;
    bit d_stalled, s_stalled, done;
    got_data.delete(); got_keep.delete(); got_last.delete(); got_cyc.delete();
    ok = 1'b0; done = 1'b0; d_stalled = 1'b0; s_stalled = 1'b0;
    hold_d = '0; hold_k = '0; hold_l = 1'b0; hold_s = '0;
    for (int b = 0; b < 3000 && !done; b++) begin
      data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sts_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (d_stalled && (!data_valid || data_data !== hold_d || data_keep !== hold_k || data_last !== hold_l))
        stall_bad++;
      if (s_stalled && (!sts_valid || sts_data !== hold_s))
        stall_bad++;
      d_stalled = data_valid && !data_ready;
      s_stalled = sts_valid && !sts_ready;
      hold_d = data_data; hold_k = data_keep; hold_l = data_last; hold_s = sts_data;
      if (data_valid && data_ready) begin
        got_data.push_back(data_data);
        got_keep.push_back(data_keep);
        got_last.push_back(data_last);
        got_cyc.push_back(cyc);
      end
      if (sts_valid && sts_ready) begin
        got_sts = sts_data;
        sts_cyc = cyc;
        done = 1'b1;
        ok = 1'b1;
      end
      @(posedge clk); @(negedge clk);
    end
    data_ready = 1'b0;
    sts_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (data_valid !== 1'b0 || sts_valid !== 1'b0 || data_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids got dv=%b sv=%b last=%b required 0 0 0", data_valid, sts_valid, data_last);
    end
    checks++;
    if (data_keep !== 64'd0 || data_data !== 512'd0) begin
      errors++;
      $display("FAIL reset_payload got keep=%h data=%h required zero", data_keep, data_data);
    end
    checks++;
    if (cmd_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_ready_state got ready=%b state=%0d required 1 0", cmd_ready, dbg_state);
    end
  endtask

  task automatic test_long();
    int hs; bit ok; int bad;
    do_reset();
    send_cmd(64'h1000, 32'd4096, hs);
    drain(1'b0, ok);
    checks++;
    if (!ok || got_data.size() != 64) begin
      errors++;
      $display("FAIL long_beats got %0d beats ok=%0d required 64 beats", got_data.size(), ok);
    end else begin
      checks++;
      if (got_cyc[0] != hs + 2) begin
        errors++;
        $display("FAIL long_latency got cycle %0d required %0d", got_cyc[0], hs + 2);
      end
      checks++;
      if (got_data[0] !== lanes(64'h1000) || got_data[63] !== lanes(64'h1FC0)) begin
        errors++;
        $display("FAIL long_payload got b0=%h b63=%h required 1000 / 1fc0 lanes", got_data[0][63:0], got_data[63][63:0]);
      end
      bad = 0;
      for (int i = 0; i < 64; i++)
        if (got_data[i] !== lanes(64'h1000 + 64'(i) * 64) || got_keep[i] !== ALL_KEEP ||
            got_last[i] !== (i == 63) || got_cyc[i] != hs + 2 + i) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL long_sequence got %0d bad beats required 0", bad);
      end
      checks++;
      if (got_sts !== 8'h00 || sts_cyc != got_cyc[63] + 1) begin
        errors++;
        $display("FAIL long_status got sts=%h at %0d required 00 at %0d", got_sts, sts_cyc, got_cyc[63] + 1);
      end
    end
  endtask

  task automatic test_partial();
    int hs; bit ok;
    do_reset();
    send_cmd(64'h0, 32'd100, hs);
    drain(1'b0, ok);
    checks++;
    if (!ok || got_data.size() != 2) begin
      errors++;
      $display("FAIL partial_beats got %0d beats required 2", got_data.size());
    end else begin
      checks++;
      if (got_keep[0] !== ALL_KEEP || got_keep[1] !== 64'h0000_000F_FFFF_FFFF ||
          got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
        errors++;
        $display("FAIL partial_keep got k0=%h k1=%h l=%b%b required ffff..ff 0000000fffffffff 01",
                 got_keep[0], got_keep[1], got_last[0], got_last[1]);
      end
      checks++;
      if (got_data[1] !== lanes(64'h40) || got_sts !== 8'h00) begin
        errors++;
        $display("FAIL partial_data_sts got b1=%h sts=%h required 40 00", got_data[1][63:0], got_sts);
      end
    end
    send_cmd(64'h800, 32'd64, hs);
    drain(1'b0, ok);
    checks++;
    if (!ok || got_data.size() != 1 || got_keep[0] !== ALL_KEEP || got_last[0] !== 1'b1 || got_sts !== 8'h01) begin
      errors++;
      $display("FAIL single_beat got beats=%0d sts=%h required 1 full beat sts 01", got_data.size(), got_sts);
    end
  endtask

  task automatic test_zero();
    int hs; bit ok;
    do_reset();
    send_cmd(64'h3000, 32'd0, hs);
    drain(1'b0, ok);
    checks++;
    if (!ok || got_data.size() != 0 || got_sts !== 8'h80) begin
      errors++;
      $display("FAIL zero_len got beats=%0d sts=%h required 0 beats sts 80", got_data.size(), got_sts);
    end
    send_cmd(64'h3000, 32'd64, hs);
    drain(1'b0, ok);
    checks++;
    if (!ok || got_data.size() != 1 || got_sts !== 8'h01) begin
      errors++;
      $display("FAIL after_zero got beats=%0d sts=%h required 1 beat sts 01", got_data.size(), got_sts);
    end
  endtask

  task automatic test_backpressure();
    int idx, acc, bad; bit ok;
    do_reset();
    data_ready = 1'b0;
    idx = 0; acc = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = (idx < 6);
      cmd_addr = 64'h10000 + 64'(idx) * 64'h1000;
      cmd_len = 32'(64 * (idx + 1));
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(8'(idx));
        acc++; idx++;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (acc != 5 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_accept got %0d accepted ready=%b required 5 and 0", acc, cmd_ready);
    end
    cmd_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      drain(1'b0, ok);
      if (!ok || exp_q.size() == 0) bad++;
      else if (got_data.size() != k + 1 || got_data[0] !== lanes(64'h10000 + 64'(k) * 64'h1000) ||
               got_sts !== exp_q.pop_front()) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fifo_drain got %0d bad bursts required 0", bad);
    end
  endtask

  task automatic test_random_ready();
    int hs, bad; bit ok;
    do_reset();
    stall_bad = 0;
    send_cmd(64'h5000, 32'd1000, hs);
    drain(1'b1, ok);
    checks++;
    if (!ok || got_data.size() != 16) begin
      errors++;
      $display("FAIL rand_beats got %0d beats required 16", got_data.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (got_data[i] !== lanes(64'h5000 + 64'(i) * 64) || got_last[i] !== (i == 15) ||
            (i < 15 && got_keep[i] !== ALL_KEEP)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL rand_sequence got %0d bad beats required 0", bad);
      end
      checks++;
      if (got_keep[15] !== 64'h0000_00FF_FFFF_FFFF || got_sts !== 8'h00) begin
        errors++;
        $display("FAIL rand_last got keep=%h sts=%h required 000000ffffffffff 00", got_keep[15], got_sts);
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL rand_stability got %0d unstable stalls required 0", stall_bad);
    end
  endtask

  task automatic test_max_length();
    int hs, nb;
    logic [511:0] d0, d1;
    logic [63:0] k0;
    logic l0;
    do_reset();
    send_cmd(64'hFFFF_FFFF_FFFF_FFC0, 32'hFFFF_FFFF, hs);
    nb = 0; d0 = '0; d1 = '0; k0 = '0; l0 = 1'b1;
    data_ready = 1'b1;
    for (int b = 0; b < 20 && nb < 2; b++) begin
      if (data_valid) begin
        if (nb == 0) begin d0 = data_data; k0 = data_keep; l0 = data_last; end
        else d1 = data_data;
        nb++;
      end
      @(posedge clk); @(negedge clk);
    end
    data_ready = 1'b0;
    checks++;
    if (nb != 2 || l0 !== 1'b0 || k0 !== ALL_KEEP || sts_valid !== 1'b0) begin
      errors++;
      $display("FAIL maxlen_first got beats=%0d last=%b keep=%h sts_valid=%b required 2 0 all-ones 0",
               nb, l0, k0, sts_valid);
    end
    checks++;
    if (d0 !== lanes(64'hFFFF_FFFF_FFFF_FFC0) || d1 !== lanes(64'h0)) begin
      errors++;
      $display("FAIL maxlen_wrap got b0=%h b1=%h required ffffffffffffffc0 0", d0[63:0], d1[63:0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int hs, nb, stray; bit ok; bit hit;
    do_reset();
    send_cmd(64'h8000, 32'd4096, hs);
    data_ready = 1'b1;
    nb = 0; hit = 1'b0;
    for (int b = 0; b < 100; b++) begin
      if (data_valid) begin
        if (nb == 10) begin
          rstn = 1'b0;
          hit = 1'b1;
          #1;
          break;
        end
        nb++;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (!hit || data_valid !== 1'b0 || sts_valid !== 1'b0 || data_last !== 1'b0 || data_keep !== 64'd0) begin
      errors++;
      $display("FAIL mid_reset_async got hit=%b dv=%b sv=%b last=%b required 1 0 0 0",
               hit, data_valid, sts_valid, data_last);
    end
    // Commands offered while in reset must not be captured.
    data_ready = 1'b1;
    sts_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr = 64'hDEAD_0000;
    cmd_len = 32'd64;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    rstn = 1'b1;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (data_valid || sts_valid) stray++;
    end
    data_ready = 1'b0;
    sts_ready = 1'b0;
    checks++;
    if (stray != 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_flush got %0d stray cycles ready=%b required 0 1", stray, cmd_ready);
    end
    send_cmd(64'h9000, 32'd128, hs);
    drain(1'b0, ok);
    checks++;
    if (!ok || got_data.size() != 2 || got_data[1] !== lanes(64'h9040) || got_sts !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_after got beats=%0d sts=%h required 2 beats sts 00", got_data.size(), got_sts);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_long();
    test_partial();
    test_zero();
    test_backpressure();
    test_random_ready();
    test_max_length();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion required finish before 2000000 time units");
    $fatal(1, "watchdog");
  end

endmodule
